// File: rtl/zx_bus_arbiter_if.sv
// zx_bus_arbiter_if -- bundle of every bus signal around the shared-RAM arbiter.
//
// Signal groups:
//   CPU side   : cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n (Z80 strobes, active low),
//                cpu_a[15:0], cpu_do[7:0] in; cpu_di[7:0], cpu_sel out.
//   Video side : vid_req, vid_addr[13:0] in; vid_ack, vid_data[7:0] out.
//   RAM side   : ram_addr[13:0], ram_we, ram_wdata[7:0] out; ram_rdata[7:0] in.
//
// Modports:
//   slave  -- the arbiter itself; it serves the CPU and video requesters
//             and drives the RAM port.
//   master -- the surroundings: CPU, video fetcher and RAM model.
//
// Handshakes: vid_req is a level, held by the requester until it sees the
// one-CLK vid_ack pulse; vid_data is valid in the same cycle as vid_ack.
// A CPU access is requested by the strobes and is serviced once per MREQ
// assertion; the CPU is held off through CLKEN until it completes. The RAM is
// synchronous: ram_rdata is valid one CLK after ram_addr is presented.
interface zx_bus_arbiter_if;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_rfsh_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_sel;

    logic        vid_req;
    logic [13:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_data;

    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_do,
        output cpu_di, cpu_sel,
        input  vid_req, vid_addr,
        output vid_ack, vid_data,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_do,
        input  cpu_di, cpu_sel,
        output vid_req, vid_addr,
        input  vid_ack, vid_data,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/zx_bus_arbiter.sv
// zx_bus_arbiter -- shares one synchronous 16 KiB RAM between a Z80 (window
// 0x4000-0x7FFF) and a video fetcher, and generates the CPU clock enable.
//
// Ports:
//   CLK       in   sole clock, rising edge
//   RESET     in   asynchronous, active-high reset
//   CLKEN     out  one-CLK CPU clock-enable pulse every CPU_DIV CLKs,
//                  withheld while a CPU access to shared RAM is pending
//   dbg_state out  current FSM state: 0 IDLE, 1 VID_ISS, 2 VID_CAP,
//                  3 CPU_ISS, 4 CPU_CAP
//   bus       --   zx_bus_arbiter_if.slave (CPU, video and RAM signals)
//
// Video normally wins the RAM. A waiting CPU access is let through after
// STARVE_MAX consecutive video grants, so the CPU is never locked out.
module zx_bus_arbiter #(
    parameter int CPU_DIV    = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              CLKEN,
    output logic [2:0]        dbg_state,
    zx_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VID_ISS = 3'd1,
        VID_CAP = 3'd2,
        CPU_ISS = 3'd3,
        CPU_CAP = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(CPU_DIV);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPU_DIV - 1);
    localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [STV_W-1:0] starve;
    logic             done;
    logic             is_wr;
    logic             cpu_req;
    logic             stall;

    assign dbg_state   = state;
    assign bus.cpu_sel = (bus.cpu_a[15:14] == 2'b01);

    // done masks the request after completion until MREQ is released, so a
    // long MREQ is serviced once. Refresh cycles never reach the RAM.
    assign cpu_req = !bus.cpu_mreq_n && bus.cpu_rfsh_n && bus.cpu_sel &&
                     (!bus.cpu_rd_n || !bus.cpu_wr_n) && !done;

    assign stall = cpu_req || (state == CPU_ISS) || (state == CPU_CAP);
    assign CLKEN = (cnt == CNT_LAST) && !stall;

    // Prescaler parks on its last count during a stall so the enable is
    // released on the very first cycle after the access completes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            if (!stall) begin
                cnt <= '0;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Addresses and write data are registered on the transition into an
    // *_ISS state, so the RAM sees them during that state and returns read
    // data during the following *_CAP state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            starve        <= '0;
            done          <= 1'b0;
            is_wr         <= 1'b0;
            bus.vid_ack   <= 1'b0;
            bus.vid_data  <= '0;
            bus.cpu_di    <= '0;
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            bus.vid_ack <= 1'b0;
            bus.ram_we  <= 1'b0;

            if (state == CPU_CAP) begin
                done <= 1'b1;
            end else if (bus.cpu_mreq_n) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.vid_req && !(cpu_req && starve == STV_LIM)) begin
                        bus.ram_addr <= bus.vid_addr;
                        state        <= VID_ISS;
                    end else if (cpu_req) begin
                        bus.ram_addr <= bus.cpu_a[13:0];
                        // The direction is latched so the access completes
                        // even if the strobes drop mid-access.
                        is_wr        <= !bus.cpu_wr_n;
                        if (!bus.cpu_wr_n) begin
                            bus.ram_we    <= 1'b1;
                            bus.ram_wdata <= bus.cpu_do;
                        end
                        state <= CPU_ISS;
                    end
                end
                VID_ISS: begin
                    state <= VID_CAP;
                end
                VID_CAP: begin
                    bus.vid_data <= bus.ram_rdata;
                    bus.vid_ack  <= 1'b1;
                    if (cpu_req) begin
                        if (starve != STV_LIM) begin
                            starve <= starve + STV_W'(1);
                        end
                    end else begin
                        starve <= '0;
                    end
                    state <= IDLE;
                end
                CPU_ISS: begin
                    state <= CPU_CAP;
                end
                CPU_CAP: begin
                    if (!is_wr) begin
                        bus.cpu_di <= bus.ram_rdata;
                    end
                    starve <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zx_bus_arbiter.sv
// tb_zx_bus_arbiter -- self-checking bench for zx_bus_arbiter.
// Drives CPU and video requests, models the synchronous RAM, and checks
// every RAM write, video read and CPU read against expected queues.
`timescale 1ns/1ps
module tb_zx_bus_arbiter;

    localparam int CPU_DIV    = 8;
    localparam int STARVE_MAX = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_VID_ISS = 3'd1;
    localparam logic [2:0] S_CPU_ISS = 3'd3;
    localparam logic [2:0] S_CPU_CAP = 3'd4;

    // ---------------- clock / reset ----------------
    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       CLKEN;
    logic [2:0] dbg_state;

    always #5 CLK = ~CLK;

    zx_bus_arbiter_if bus();

    zx_bus_arbiter #(
        .CPU_DIV   (CPU_DIV),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLKEN    (CLKEN),
        .dbg_state(dbg_state),
        .bus      (bus)
    );

    // ---------------- synchronous RAM model with backdoor preload ----------------
    logic [7:0]  mem [0:16383];
    logic        bd_we   = 1'b0;
    logic [13:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    always @(posedge CLK) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  vid_exp_q[$];
    logic [7:0]  cpu_exp_q[$];
    logic [21:0] we_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int   iss_cnt = 0;
    logic cap_prev = 1'b0;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (bus.vid_ack) begin
                if (vid_exp_q.size() == 0) check("vid_unexpected", 1, 0);
                else check("vid_data", bus.vid_data, vid_exp_q.pop_front());
            end
            if (bus.ram_we) begin
                if (we_exp_q.size() == 0) check("we_unexpected", 1, 0);
                else check("ram_write", {bus.ram_addr, bus.ram_wdata}, we_exp_q.pop_front());
            end
            if (cap_prev && cpu_exp_q.size() != 0) begin
                check("cpu_di", bus.cpu_di, cpu_exp_q.pop_front());
            end
            if (dbg_state == S_CPU_ISS) iss_cnt <= iss_cnt + 1;
        end
        cap_prev <= !RESET && (dbg_state == S_CPU_CAP);
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        @(negedge CLK);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge CLK);
        bd_we = 1'b0;
    endtask

    task automatic cpu_release();
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        bus.cpu_wr_n   = 1'b1;
        bus.cpu_rfsh_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (dbg_state == s) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_clken(input int budget, input string tag, output int k);
        k = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            k++;
            if (CLKEN) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_ack(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.vid_ack) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_cpu(input logic [15:0] a, input bit wr, input logic [7:0] d);
        if (wr) we_exp_q.push_back({a[13:0], d});
        else begin
            preload(a[13:0], d);
            cpu_exp_q.push_back(d);
        end
        @(negedge CLK);
        bus.cpu_a = a; bus.cpu_do = d;
        bus.cpu_rd_n = wr; bus.cpu_wr_n = !wr; bus.cpu_mreq_n = 1'b0;
        wait_state(S_CPU_CAP, 12, "cpu_cap");
        @(negedge CLK);
        cpu_release();
        @(negedge CLK);
        if (wr) check("mem_after_write", mem[a[13:0]], d);
    endtask

    task automatic do_vid(input logic [13:0] a, input logic [7:0] d);
        preload(a, d);
        vid_exp_q.push_back(d);
        @(negedge CLK);
        bus.vid_addr = a; bus.vid_req = 1'b1;
        wait_ack(8, "vid_ack");
        bus.vid_req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     dbg_state,     S_IDLE);
        check({tag, "_clken"},     CLKEN,         0);
        check({tag, "_vid_ack"},   bus.vid_ack,   0);
        check({tag, "_ram_we"},    bus.ram_we,    0);
        check({tag, "_ram_addr"},  bus.ram_addr,  0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        check({tag, "_cpu_di"},    bus.cpu_di,    0);
        check({tag, "_vid_data"},  bus.vid_data,  0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int iss_base;
        int acks;
        int acks_before;
        int pulses;
        logic flag;
        logic [15:0] ra;
        logic [7:0]  rd;

        cpu_release();
        bus.cpu_a = '0; bus.cpu_do = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        #1 check_reset_values("rst");

        // Free-running prescaler: cnt reaches CPU_DIV-1 after CPU_DIV-1 edges,
        // the pulse is taken on edge CPU_DIV.
        @(negedge CLK);
        RESET = 1'b0;
        wait_clken(3 * CPU_DIV, "clken_first", k);
        check("clken_first_edge", k + 1, CPU_DIV);
        for (int i = 0; i < 3; i++) begin
            wait_clken(3 * CPU_DIV, "clken_period", k);
            check("clken_period", k, CPU_DIV);
        end

        // CPU read 0x4123, request raised while the prescaler sits on its last count
        preload(14'h0123, 8'h5A);
        wait_clken(3 * CPU_DIV, "t_rd_align", k);
        cpu_exp_q.push_back(8'h5A);
        bus.cpu_a = 16'h4123; bus.cpu_rd_n = 1'b0; bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b0;
        #1;
        check("rd_cpu_sel", bus.cpu_sel, 1);
        check("rd_clken_withheld", CLKEN, 0);
        iss_base = iss_cnt;
        @(negedge CLK);
        check("rd_state_iss", dbg_state, S_CPU_ISS);
        check("rd_ram_addr", bus.ram_addr, 14'h0123);
        check("rd_ram_we", bus.ram_we, 0);
        check("rd_clken_iss", CLKEN, 0);
        @(negedge CLK);
        check("rd_state_cap", dbg_state, S_CPU_CAP);
        check("rd_clken_cap", CLKEN, 0);
        @(negedge CLK);
        check("rd_clken_release", CLKEN, 1);
        @(negedge CLK);
        check("rd_clken_wrap", CLKEN, 0);
        repeat (4) @(negedge CLK);
        #1 check("rd_one_access", iss_cnt - iss_base, 1);
        cpu_release();
        repeat (2) @(negedge CLK);

        // CPU write 0xA5 to 0x7FFF raised while video is in VID_ISS
        preload(14'h0777, 8'hC3);
        preload(14'h3FFF, 8'h00);
        @(negedge CLK);
        vid_exp_q.push_back(8'hC3);
        bus.vid_addr = 14'h0777; bus.vid_req = 1'b1;
        wait_state(S_VID_ISS, 4, "wr_vid_iss");
        we_exp_q.push_back({14'h3FFF, 8'hA5});
        bus.cpu_a = 16'h7FFF; bus.cpu_do = 8'hA5;
        bus.cpu_wr_n = 1'b0; bus.cpu_rd_n = 1'b1; bus.cpu_mreq_n = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 8 && !bus.vid_ack; i++) begin
            @(negedge CLK);
            if (bus.ram_we) flag = 1'b1;
        end
        check("wr_vid_acked", bus.vid_ack, 1);
        check("wr_no_write_before_vid", flag, 0);
        bus.vid_req = 1'b0;
        wait_state(S_CPU_CAP, 8, "wr_cpu_cap");
        wait_clken(CPU_DIV + 1, "wr_clken_release", k);
        check("wr_mem", mem[14'h3FFF], 8'hA5);
        cpu_release();
        repeat (2) @(negedge CLK);

        // Starvation limit: video held, CPU read pending from the same cycle
        preload(14'h0200, 8'h33);
        preload(14'h0456, 8'h77);
        @(negedge CLK);
        for (int i = 0; i < 6; i++) vid_exp_q.push_back(8'h33);
        cpu_exp_q.push_back(8'h77);
        bus.vid_addr = 14'h0200; bus.vid_req = 1'b1;
        bus.cpu_a = 16'h4456; bus.cpu_rd_n = 1'b0; bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b0;
        @(negedge CLK);
        check("stv_video_first", dbg_state, S_VID_ISS);
        acks = 0; acks_before = -1;
        for (int i = 0; i < 100 && acks < 6; i++) begin
            @(negedge CLK);
            if (bus.vid_ack) acks++;
            if (dbg_state == S_CPU_ISS && acks_before < 0) acks_before = acks;
            if (acks == 6) bus.vid_req = 1'b0;
        end
        check("stv_acks_before_cpu", acks_before, STARVE_MAX);
        check("stv_video_resumed", acks, 6);
        cpu_release();
        repeat (3) @(negedge CLK);

        // Refresh in the shared window, then a read outside it: no RAM, no stall
        for (int p = 0; p < 2; p++) begin
            @(negedge CLK);
            bus.cpu_a = (p == 0) ? 16'h4000 : 16'h8000;
            bus.cpu_rfsh_n = (p == 0) ? 1'b0 : 1'b1;
            bus.cpu_rd_n = 1'b0; bus.cpu_mreq_n = 1'b0;
            #1 check("nr_cpu_sel", bus.cpu_sel, (p == 0) ? 1 : 0);
            pulses = 0; flag = 1'b0;
            for (int i = 0; i < 2 * CPU_DIV; i++) begin
                @(negedge CLK);
                if (CLKEN) pulses++;
                if (dbg_state != S_IDLE) flag = 1'b1;
            end
            check("nr_clken_pulses", pulses, 2);
            check("nr_no_access", flag, 0);
            cpu_release();
        end

        // Randomised video reads and CPU reads/writes
        for (int i = 0; i < 4; i++) begin
            do_vid(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)));
            @(negedge CLK);
        end
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(16'h4000, 16'h7FFF));
            rd = 8'($urandom_range(0, 255));
            do_cpu(ra, bit'(i % 2), rd);
        end

        // Reset during CPU_ISS of a write aborts it
        preload(14'h1000, 8'h11);
        @(negedge CLK);
        we_exp_q.push_back({14'h1000, 8'h3C});
        bus.cpu_a = 16'h5000; bus.cpu_do = 8'h3C;
        bus.cpu_wr_n = 1'b0; bus.cpu_mreq_n = 1'b0;
        wait_state(S_CPU_ISS, 6, "rw_iss");
        #2 RESET = 1'b1;
        cpu_release();
        #1 check_reset_values("rst_mid");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check("rst_write_aborted", mem[14'h1000], 8'h11);
        wait_clken(3 * CPU_DIV, "rst_clken_first", k);
        check("rst_clken_first_edge", k + 1, CPU_DIV);
        flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (bus.ram_we || dbg_state != S_IDLE) flag = 1'b1;
        end
        check("rst_no_more_access", flag, 0);
        do_cpu(16'h5000, 1'b1, 8'h3C);

        repeat (4) @(negedge CLK);
        check("vid_q_empty", vid_exp_q.size(), 0);
        check("cpu_q_empty", cpu_exp_q.size(), 0);
        check("we_q_empty",  we_exp_q.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zx_bus_arbiter.md
ZX_BUS_ARBITER -- requirements
Module: zx_bus_arbiter

Interface
REQ-001 Parameter CPU_DIV, default 8: CLK cycles per CPU clock-enable pulse; legal range 4..16.
REQ-002 Parameter STARVE_MAX, default 4: maximum consecutive video grants while a CPU request waits.
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n  in  1 each  Z80 strobes, active low.
REQ-006 cpu_a  in  16  CPU address.
REQ-007 cpu_do  in  8  CPU write data.
REQ-008 cpu_di  out  8  latched shared-RAM read data for the CPU.
REQ-009 cpu_sel  out  1  combinational; 1 when cpu_a[15:14]==2'b01, i.e. shared RAM 0x4000-0x7FFF.
REQ-010 CLKEN  out  1  CPU clock enable, one-CLK pulse.
REQ-011 vid_req  in  1  video fetch request, level, held until vid_ack.
REQ-012 vid_addr  in  14  video fetch address.
REQ-013 vid_ack  out  1  one-CLK pulse; vid_data valid in the same cycle.
REQ-014 vid_data  out  8  video read data.
REQ-015 ram_addr  out  14, ram_we  out  1, ram_wdata  out  8, ram_rdata  in  8  synchronous RAM port; read data is valid one CLK after the address.

Function
REQ-016 cpu_req = !cpu_mreq_n & cpu_rfsh_n & cpu_sel & (!cpu_rd_n | !cpu_wr_n) & !done. Refresh cycles never touch RAM.
REQ-017 done sets when a CPU access completes.
REQ-018 done clears on the first CLK with cpu_mreq_n high; each MREQ assertion is therefore serviced exactly once.
REQ-019 FSM states are IDLE, VID_ISS, VID_CAP, CPU_ISS and CPU_CAP.
REQ-020 IDLE transitions:
- vid_req & !(cpu_req & starve==STARVE_MAX) -> VID_ISS.
- else cpu_req -> CPU_ISS.
- else stay in IDLE.
REQ-021 VID_ISS: ram_addr=vid_addr, ram_we=0 -> VID_CAP.
REQ-022 VID_CAP: vid_data<=ram_rdata, vid_ack=1; starve increments if cpu_req, else clears; -> IDLE.
REQ-023 CPU_ISS: ram_addr=cpu_a[13:0]. If !cpu_wr_n: ram_we=1 and ram_wdata=cpu_do. Then -> CPU_CAP.
REQ-024 CPU_CAP: on a read, cpu_di<=ram_rdata; done<=1, starve<=0 -> IDLE.
REQ-025 Outside VID_ISS and CPU_ISS, ram_we is 0; ram_addr and ram_wdata hold their last values.
REQ-026 Video grant latency is at most 4 CLK from vid_req, i.e. one in-flight CPU access plus issue.
REQ-027 CPU grant latency is bounded by (STARVE_MAX+1)*3 CLK.
REQ-028 Prescaler cnt runs 0..CPU_DIV-1 and wraps to 0.
REQ-029 CLKEN=1 exactly when cnt==CPU_DIV-1 and !stall, where stall = cpu_req | state∈{CPU_ISS,CPU_CAP}.
REQ-030 While stall is high, cnt holds at CPU_DIV-1 and CLKEN stays 0; on the first non-stall cycle, CLKEN pulses and cnt wraps to 0.
REQ-031 Accesses with cpu_sel=0 never stall the CPU and never reach the RAM port.
REQ-032 vid_req and cpu_req rising on the same cycle in IDLE: video wins unless starve==STARVE_MAX.
REQ-033 vid_req dropped before grant: IDLE does not issue; a grant already issued completes normally.
REQ-034 CPU strobes deasserted mid-access (CPU_ISS/CPU_CAP): the access completes; done then clears per REQ-018.

Reset
REQ-035 While RESET=1, the block SHALL hold:
- state=IDLE, cnt=0, starve=0, done=0.
- CLKEN=0, vid_ack=0, ram_we=0.
- ram_addr=0, ram_wdata=0, cpu_di=0, vid_data=0.
REQ-036 Deassertion of RESET SHALL take effect on the next CLK edge.
REQ-037 RESET asserted mid-access SHALL abort the access with no ram_we pulse after reset.

Verification
REQ-038 Free-run, no requests, CPU_DIV=8 -> CLKEN pulses every 8 CLK, first pulse 8 CLK after reset release.
REQ-039 CPU read at 0x4123, RAM holds 0x5A, no video -> RAM address 0x0123, one RAM read, cpu_di=0x5A, CLKEN withheld for the 3-CLK stall, one access only.
REQ-040 CPU write 0xA5 to 0x7FFF with vid_req already in VID_ISS -> video completes first; ram_we pulses once with ram_addr=0x3FFF and ram_wdata=0xA5; CLKEN is then released.
REQ-041 vid_req held continuously, CPU read pending, STARVE_MAX=4 -> exactly 4 vid_ack pulses, then the CPU access, then video resumes.
REQ-042 Refresh cycle (cpu_rfsh_n=0, cpu_mreq_n=0, cpu_a=0x4000) and a read at 0x8000 -> no RAM access, no stall.
REQ-043 RESET pulsed during CPU_ISS of a write -> all outputs at reset values; no further ram_we until a new request.
